// File: rtl/traffic_request_latch_if.sv
// traffic_request_latch_if: road button, green-light and request/ack signals
// between the traffic controller top level and traffic_request_latch.
//
// Handshake: req_x is a level that rises one cycle after an accepted press and
// stays high until the state machine shows green_x. The cycle after green_x
// is sampled high with req_x up, req_x drops and ack_x pulses for exactly one
// cycle. Requests do not queue: presses while req_x is high are dropped.
interface traffic_request_latch_if;
    logic [1:0] btn_a_raw;
    logic [1:0] btn_b_raw;
    logic       green_a;
    logic       green_b;
    logic       one_sec_tick;
    logic       req_a;
    logic       req_b;
    logic       ack_a;
    logic       ack_b;
    logic [3:0] wait_a;
    logic [3:0] wait_b;

    // Side that owns the buttons, the lights and the tick.
    modport master (
        output btn_a_raw, btn_b_raw, green_a, green_b, one_sec_tick,
        input  req_a, req_b, ack_a, ack_b, wait_a, wait_b
    );

    // Request latch side.
    modport slave (
        input  btn_a_raw, btn_b_raw, green_a, green_b, one_sec_tick,
        output req_a, req_b, ack_a, ack_b, wait_a, wait_b
    );
endinterface

// File: rtl/traffic_request_latch.sv
// traffic_request_latch: per-road button synchroniser, debouncer, press-edge
// detector and request FSM. Road A is index 0, road B is index 1.
// Optional macro REQ_WAIT_COUNT_EN adds a saturating seconds-pending counter
// per road (wait_a / wait_b); without it those outputs are tied to zero.
// State encodings on state_a_dbg / state_b_dbg:
//   0 = IDLE, 1 = PENDING, 2 = ACK, 3 = WAIT_RELEASE.
module traffic_request_latch #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic                          CLK100MHZ,
    input  logic                          reset,
    traffic_request_latch_if.slave        bus,
    output logic [1:0]                    state_a_dbg,
    output logic [1:0]                    state_b_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PENDING      = 2'd1,
        ST_ACK          = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] btn_any;
    logic [1:0] green;
    logic [1:0] req_vec;
    logic [1:0] ack_vec;
    logic [3:0] wait_vec  [2];
    logic [1:0] state_vec [2];

    assign btn_any = {|bus.btn_b_raw, |bus.btn_a_raw};
    assign green   = {bus.green_b, bus.green_a};

    for (genvar r = 0; r < 2; r++) begin : g_road
        logic             sync1_q, sync1_d;
        logic             sync2_q, sync2_d;
        logic             deb_q, deb_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             deb_prev_q, deb_prev_d;
        logic             press_q, press_d;
        logic [1:0]       fill_q, fill_d;
        logic             arm_q, arm_d;
        state_t           state_q, state_d;

        // Front end: two-flop synchroniser, stability-counter debounce, and a
        // registered rising-edge detect on the debounced level. A press only
        // counts once the road has been seen released (arm_q), so a button
        // held across reset cannot raise a request until it is let go; fill_q
        // waits for the synchroniser to hold a real sample before arming.
        always_comb begin
            sync1_d    = btn_any[r];
            sync2_d    = sync1_q;
            fill_d     = {fill_q[0], 1'b1};
            deb_d      = deb_q;
            cnt_d      = cnt_q;
            if (sync2_q == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            deb_prev_d = deb_q;
            arm_d      = arm_q | (fill_q[1] & ~sync2_q & ~deb_q);
            press_d    = deb_q & ~deb_prev_q & arm_q;
        end

        // Request FSM next state; unused encodings fall back to IDLE.
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE: begin
                    if (press_q) begin
                        state_d = green[r] ? ST_WAIT_RELEASE : ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (green[r]) begin
                        state_d = ST_ACK;
                    end
                end
                ST_ACK: begin
                    state_d = deb_q ? ST_WAIT_RELEASE : ST_IDLE;
                end
                ST_WAIT_RELEASE: begin
                    if (!deb_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Front-end and FSM registers with synchronous reset.
        always_ff @(posedge CLK100MHZ) begin
            if (reset) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                deb_q      <= 1'b0;
                cnt_q      <= '0;
                deb_prev_q <= 1'b0;
                press_q    <= 1'b0;
                fill_q     <= 2'b00;
                arm_q      <= 1'b0;
                state_q    <= ST_IDLE;
            end else begin
                sync1_q    <= sync1_d;
                sync2_q    <= sync2_d;
                deb_q      <= deb_d;
                cnt_q      <= cnt_d;
                deb_prev_q <= deb_prev_d;
                press_q    <= press_d;
                fill_q     <= fill_d;
                arm_q      <= arm_d;
                state_q    <= state_d;
            end
        end

        assign req_vec[r]   = (state_q == ST_PENDING);
        assign ack_vec[r]   = (state_q == ST_ACK);
        assign state_vec[r] = state_q;

`ifdef REQ_WAIT_COUNT_EN
        logic [3:0] wait_q, wait_d;

        // Seconds pending: count ticks in PENDING (saturating), hold in ACK
        // so the final value can be shown, clear everywhere else.
        always_comb begin
            wait_d = '0;
            case (state_q)
                ST_PENDING: begin
                    if (bus.one_sec_tick && (wait_q != 4'd15)) begin
                        wait_d = wait_q + 4'd1;
                    end else begin
                        wait_d = wait_q;
                    end
                end
                ST_ACK: begin
                    wait_d = wait_q;
                end
                default: begin
                    wait_d = '0;
                end
            endcase
        end

        // Wait counter register.
        always_ff @(posedge CLK100MHZ) begin
            if (reset) begin
                wait_q <= '0;
            end else begin
                wait_q <= wait_d;
            end
        end

        assign wait_vec[r] = wait_q;
`else
        assign wait_vec[r] = 4'd0;
`endif
    end

`ifndef REQ_WAIT_COUNT_EN
    logic unused_tick;
    assign unused_tick = bus.one_sec_tick;
`endif

    assign bus.req_a  = req_vec[0];
    assign bus.req_b  = req_vec[1];
    assign bus.ack_a  = ack_vec[0];
    assign bus.ack_b  = ack_vec[1];
    assign bus.wait_a = wait_vec[0];
    assign bus.wait_b = wait_vec[1];
    assign state_a_dbg = state_vec[0];
    assign state_b_dbg = state_vec[1];

endmodule

// File: tb/tb_traffic_request_latch.sv
// tb_traffic_request_latch: directed bench for traffic_request_latch with
// DEBOUNCE_CYCLES=4. Expected wait counts depend on REQ_WAIT_COUNT_EN.
module tb_traffic_request_latch;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_a_dbg;
    logic [1:0] state_b_dbg;
    int         n_cmp = 0;
    int         n_err = 0;

    traffic_request_latch_if bus();

    traffic_request_latch #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .CLK100MHZ   (clk),
        .reset       (reset),
        .bus         (bus),
        .state_a_dbg (state_a_dbg),
        .state_b_dbg (state_b_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_wait(input int n);
`ifdef REQ_WAIT_COUNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic tick_pulses(input int n);
        repeat (n) begin
            bus.one_sec_tick = 1'b1;
            step(1);
            bus.one_sec_tick = 1'b0;
            step(1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_a"}, bus.req_a, 0);
        chk({tag, "_req_b"}, bus.req_b, 0);
        chk({tag, "_ack_a"}, bus.ack_a, 0);
        chk({tag, "_ack_b"}, bus.ack_b, 0);
        chk({tag, "_wait_a"}, bus.wait_a, 0);
        chk({tag, "_wait_b"}, bus.wait_b, 0);
        chk({tag, "_state_a"}, state_a_dbg, 0);
        chk({tag, "_state_b"}, state_b_dbg, 0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.btn_a_raw    = 2'b00;
        bus.btn_b_raw    = 2'b00;
        bus.green_a      = 1'b0;
        bus.green_b      = 1'b0;
        bus.one_sec_tick = 1'b0;
        step(3);
        chk_all_zero("reset");
        reset = 1'b0;
        step(4);

        // Road A press: req_a rises on the 8th edge after the raw edge.
        bus.btn_a_raw = 2'b01;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("t1_req_a_early", bus.req_a, 0);
        end
        step(1);
        chk("t1_req_a_rise", bus.req_a, 1);
        chk("t1_req_b", bus.req_b, 0);
        chk("t1_state_a", state_a_dbg, 1);
        step(11);
        chk("t1_req_a_hold", bus.req_a, 1);
        chk("t1_ack_a", bus.ack_a, 0);

        // Wait counter while pending: 5 ticks, then saturate after 20.
        tick_pulses(5);
        chk("wait_a_5", bus.wait_a, exp_wait(5));
        chk("wait_b_idle", bus.wait_b, 0);
        tick_pulses(15);
        chk("wait_a_sat", bus.wait_a, exp_wait(15));

        // Serve road A with the button still held.
        bus.green_a = 1'b1;
        step(1);
        chk("t3_ack_a", bus.ack_a, 1);
        chk("t3_req_a_fall", bus.req_a, 0);
        chk("t3_wait_a_ack", bus.wait_a, exp_wait(15));
        chk("t3_state_ack", state_a_dbg, 2);
        bus.green_a = 1'b0;
        step(1);
        chk("t3_ack_a_once", bus.ack_a, 0);
        chk("t3_state_wr", state_a_dbg, 3);
        step(1);
        chk("t3_wait_a_clr", bus.wait_a, 0);

        // Short release glitch while held: no new request.
        bus.btn_a_raw = 2'b00;
        step(2);
        bus.btn_a_raw = 2'b01;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("t3_no_rereq", bus.req_a, 0);
        end
        chk("t3_state_still_wr", state_a_dbg, 3);
        bus.btn_a_raw = 2'b00;
        step(8);
        chk("t3_idle", state_a_dbg, 0);

        // Road B 3-cycle pulse: shorter than the debounce window.
        bus.btn_b_raw = 2'b10;
        step(3);
        bus.btn_b_raw = 2'b00;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("t2_req_b_glitch", bus.req_b, 0);
        end
        chk("t2_state_b", state_b_dbg, 0);

        // Press A while already green: discarded.
        bus.green_a   = 1'b1;
        bus.btn_a_raw = 2'b10;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("t4_req_a_green", bus.req_a, 0);
            chk("t4_ack_a_green", bus.ack_a, 0);
        end
        chk("t4_state_wr", state_a_dbg, 3);
        bus.btn_a_raw = 2'b00;
        step(8);
        chk("t4_idle", state_a_dbg, 0);
        bus.green_a   = 1'b0;
        bus.btn_a_raw = 2'b01;
        step(8);
        chk("t4_req_a", bus.req_a, 1);
        bus.green_a = 1'b1;
        step(1);
        chk("t4_ack_a", bus.ack_a, 1);
        bus.green_a   = 1'b0;
        bus.btn_a_raw = 2'b00;
        step(10);
        chk("t4_back_idle", state_a_dbg, 0);
        chk("t4_req_a_low", bus.req_a, 0);

        // Both roads together, then reset mid-request.
        bus.btn_a_raw = 2'b01;
        bus.btn_b_raw = 2'b01;
        step(7);
        chk("t5_req_a_early", bus.req_a, 0);
        chk("t5_req_b_early", bus.req_b, 0);
        step(1);
        chk("t5_req_a", bus.req_a, 1);
        chk("t5_req_b", bus.req_b, 1);
        step(3);
        reset = 1'b1;
        step(1);
        chk_all_zero("t5_reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("t5_held_req_a", bus.req_a, 0);
            chk("t5_held_req_b", bus.req_b, 0);
        end
        chk("t5_held_state_a", state_a_dbg, 0);
        chk("t5_held_state_b", state_b_dbg, 0);
        bus.btn_a_raw = 2'b00;
        bus.btn_b_raw = 2'b00;
        step(10);
        bus.btn_a_raw = 2'b10;
        bus.btn_b_raw = 2'b10;
        step(8);
        chk("t5_repress_a", bus.req_a, 1);
        chk("t5_repress_b", bus.req_b, 1);
        tick_pulses(3);
        chk("t5_wait_a_3", bus.wait_a, exp_wait(3));
        chk("t5_wait_b_3", bus.wait_b, exp_wait(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
